fifo_spi_serializer: RTL



---
 rtl/serializer_pkg.sv | 22 ++
 rtl/spi_clk_divider.sv | 44 ++++
 rtl/fifo_spi_serializer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/serializer_pkg.sv
// Shared definitions for the FIFO-to-SPI serializer.
//   WORD_W      : width of a FIFO sample word
//   state_t     : serializer FSM state encoding
//   even_parity : parity bit that makes the total count of ones even
package serializer_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_LOAD,
    ST_SHIFT,
    ST_NEXT,
    ST_GAP
  } state_t;

  function automatic logic even_parity(input logic [WORD_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/spi_clk_divider.sv
// SCLK generator for the serializer.
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset
//   run   : counts while high; when low the divider is cleared and SCLK parks low
//   sclk  : registered serial clock level
//   rise  : high in the cycle whose closing edge drives sclk 0->1
//   fall  : high in the cycle whose closing edge drives sclk 1->0
module spi_clk_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int DW = $clog2(CLK_DIV) + 1;

  logic [DW-1:0] div_cnt;
  logic          tc;

  assign tc   = run && (div_cnt == DW'(CLK_DIV - 1));
  assign rise = tc && !sclk;
  assign fall = tc && sclk;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (tc) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_spi_serializer.sv
// Pops 16-bit words from the sample FIFO and shifts them out MSB-first on a
// mode-0 SPI link, grouping up to BURST_LEN words per CS_N frame.
// Optional build macro: PARITY_EN appends an even-parity bit after bit 0.
// Ports:
//   CLK, RESET           : clock, synchronous active-high reset
//   ENABLE               : allows a new frame to start (looked at only in IDLE)
//   FIFO_EMPTY/FIFO_DOUT : FIFO read side (data valid the cycle after FIFO_RD_EN)
//   FIFO_RD_EN           : one-cycle pop strobe
//   SCLK, MOSI, CS_N     : serial link
//   BUSY                 : high whenever the FSM is not in IDLE
//   WORD_DONE            : one-cycle pulse after the last bit of each word
//   UNDERRUN             : one-cycle pulse when a frame closes early on an empty FIFO
module fifo_spi_serializer
  import serializer_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int BURST_LEN  = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic              FIFO_EMPTY,
  input  logic [WORD_W-1:0] FIFO_DOUT,
  output logic              FIFO_RD_EN,
  output logic              SCLK,
  output logic              MOSI,
  output logic              CS_N,
  output logic              BUSY,
  output logic              WORD_DONE,
  output logic              UNDERRUN
);

`ifdef PARITY_EN
  localparam int NBITS = WORD_W + 1;
`else
  localparam int NBITS = WORD_W;
`endif
  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_t           state;
  logic [NBITS-1:0] shreg;
  logic [4:0]       bit_cnt;
  logic [7:0]       word_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             run;
  logic             sclk_rise;
  logic             sclk_fall;

  assign run = (state == ST_SHIFT);

  spi_clk_divider #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk  (CLK),
    .reset(RESET),
    .run  (run),
    .sclk (SCLK),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      gap_cnt    <= '0;
      FIFO_RD_EN <= 1'b0;
      MOSI       <= 1'b0;
      CS_N       <= 1'b1;
      BUSY       <= 1'b0;
      WORD_DONE  <= 1'b0;
      UNDERRUN   <= 1'b0;
    end else begin
      FIFO_RD_EN <= 1'b0;
      WORD_DONE  <= 1'b0;
      UNDERRUN   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ENABLE && !FIFO_EMPTY) begin
            FIFO_RD_EN <= 1'b1;
            BUSY       <= 1'b1;
            state      <= ST_POP;
          end
        end
        ST_POP: begin
          state <= ST_LOAD;
        end
        ST_LOAD: begin
`ifdef PARITY_EN
          shreg <= {FIFO_DOUT, even_parity(FIFO_DOUT)};
`else
          shreg <= FIFO_DOUT;
`endif
          MOSI    <= FIFO_DOUT[WORD_W-1];
          CS_N    <= 1'b0;
          bit_cnt <= '0;
          state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (sclk_rise) begin
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (sclk_fall) begin
            shreg <= shreg << 1;
            MOSI  <= shreg[NBITS-2];
            // bit_cnt already counts every rising edge of this word, so the
            // fall that follows the last rise closes the word.
            if (bit_cnt == 5'(NBITS)) begin
              WORD_DONE <= 1'b1;
              word_cnt  <= word_cnt + 1'b1;
              bit_cnt   <= '0;
              state     <= ST_NEXT;
            end
          end
        end
        ST_NEXT: begin
          if ((word_cnt < 8'(BURST_LEN)) && !FIFO_EMPTY) begin
            FIFO_RD_EN <= 1'b1;
            state      <= ST_POP;
          end else begin
            UNDERRUN <= (word_cnt < 8'(BURST_LEN));
            CS_N     <= 1'b1;
            MOSI     <= 1'b0;
            gap_cnt  <= GW'(GAP_CYCLES - 1);
            state    <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            word_cnt <= '0;
            BUSY     <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
